alu_share_arbiter: RTL and testbench

Arbitrates two requesters for the single 16-bit ALU in the execute stage: requester 0 is the instruction execute path, requester 1 is address generation (load/store effective address, branch target). Owns the architectural carry/zero flag registers, resolves conditional-write opcodes against them, and returns a registered result with a write-enable to the granted requester. One operation is in flight at a time; responses are held under backpressure.

---
 rtl/alu_share_arbiter_pkg.sv | 44 ++++
 rtl/alu_share_arbiter_grant.sv | 34 +++
 rtl/alu_share_arbiter.sv | 158 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for alu_share_arbiter: ALU control layout, op codes, FSM states.
// Arbitration mode is selected with ALU_ARB_ROUND_ROBIN_EN (see alu_arb_grant).
package alu_share_arbiter_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CTRL_W     = 6;

  // alu_control bit positions
  localparam int COND_C = 5;
  localparam int COND_Z = 4;
  localparam int OP_HI  = 3;
  localparam int OP_LO  = 2;
  localparam int UPD_Z  = 1;
  localparam int UPD_C  = 0;

  typedef enum logic [1:0] {
    ALU_ADD     = 2'b00,
    ALU_NAND    = 2'b01,
    ALU_SUB     = 2'b10,
    ALU_ADD_ALT = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_0    = 2'b01;
  localparam logic [1:0] GRANT_1    = 2'b10;

  // Address generation may only select the operation; conditions and flag updates are stripped.
  localparam logic [CTRL_W-1:0] REQ1_OP_MASK = 6'b001100;

  function automatic logic [CTRL_W-1:0] mask_req1_op(input logic [CTRL_W-1:0] op);
    return op & REQ1_OP_MASK;
  endfunction

  function automatic logic cond_write(input logic [CTRL_W-1:0] ctrl, input logic c, input logic z);
    return (~ctrl[COND_C] | c) & (~ctrl[COND_Z] | z);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_grant.sv
// Two-way grant vector from request valids. ALU_ARB_ROUND_ROBIN_EN adds a priority
// input that breaks ties; without it requester 0 always wins a tie.
module alu_arb_grant
  import alu_share_arbiter_pkg::*;
(
  input  logic [1:0] valid,
`ifdef ALU_ARB_ROUND_ROBIN_EN
  input  logic       prio,
`endif
  output logic [1:0] grant
);

  // Grant decode; single requests are granted the same way in both builds
  always_comb begin
    grant = GRANT_NONE;
    case (valid)
      2'b01: grant = GRANT_0;
      2'b10: grant = GRANT_1;
      2'b11: begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
        if (prio) begin
          grant = GRANT_1;
        end else begin
          grant = GRANT_0;
        end
`else
        grant = GRANT_0;
`endif
      end
      default: grant = GRANT_NONE;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between the execute path (req 0) and address generation (req 1),
// owns the C/Z flags. Define ALU_ARB_ROUND_ROBIN_EN for round-robin tie breaking.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [5:0]        req0_op,
  input  logic [5:0]        req1_op,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_wr_en,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [5:0]        alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              flag_c,
  output logic              flag_z
);

  arb_state_t        state_r;
  arb_state_t        state_nxt_s;
  logic [1:0]        grant_s;
  logic              gnt_idx_r;
  logic              accept_s;
  logic              rsp_done_s;
  logic              wr_s;
  logic [DATA_W-1:0] sel_a_s;
  logic [DATA_W-1:0] sel_b_s;
  logic [5:0]        sel_op_s;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic              prio_r;
`endif

  alu_arb_grant u_grant (
    .valid (req_valid),
`ifdef ALU_ARB_ROUND_ROBIN_EN
    .prio  (prio_r),
`endif
    .grant (grant_s)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and handshakes; IDLE is re-entered only through the state register,
  // so rsp_ready never reaches req_ready combinationally
  always_comb begin
    state_nxt_s = state_r;
    req_ready   = GRANT_NONE;
    accept_s    = 1'b0;
    rsp_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req_ready = grant_s;
        if (grant_s != GRANT_NONE) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready[gnt_idx_r]) begin
          rsp_done_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand/op selection for the winning requester
  always_comb begin
    sel_a_s  = req0_a;
    sel_b_s  = req0_b;
    sel_op_s = req0_op;
    if (grant_s[1]) begin
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
      sel_op_s = mask_req1_op(req1_op);
    end else begin
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
      sel_op_s = req0_op;
    end
  end

  assign wr_s = cond_write(alu_control, flag_c, flag_z);

  // Datapath: operand capture on accept, result/flag capture in EXEC, response hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_idx_r   <= 1'b0;
      alu_a       <= {DATA_W{1'b0}};
      alu_b       <= {DATA_W{1'b0}};
      alu_control <= 6'b000000;
      rsp_data    <= {DATA_W{1'b0}};
      rsp_wr_en   <= 1'b0;
      rsp_valid   <= 2'b00;
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
    end else begin
      if (accept_s) begin
        gnt_idx_r   <= grant_s[1];
        alu_a       <= sel_a_s;
        alu_b       <= sel_b_s;
        alu_control <= sel_op_s;
      end
      if (state_r == ST_EXEC) begin
        rsp_data  <= alu_result;
        rsp_wr_en <= wr_s;
        rsp_valid <= gnt_idx_r ? GRANT_1 : GRANT_0;
        if (wr_s && alu_control[UPD_C]) begin
          flag_c <= alu_carry;
        end
        if (wr_s && alu_control[UPD_Z]) begin
          flag_z <= (alu_result == {DATA_W{1'b0}});
        end
      end
      if (rsp_done_s) begin
        rsp_valid <= 2'b00;
      end
    end
  end

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Tie-break pointer: prefer whichever requester was not granted last
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_r <= 1'b0;
    end else if (accept_s) begin
      prio_r <= ~grant_s[1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: driver predicts grants/results from a behavioural
// model and queues them; a monitor pops and compares each response.
module tb_alu_share_arbiter;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [5:0]    req0_op, req1_op;
  logic [DW-1:0] rsp_data, alu_a, alu_b, alu_result;
  logic          rsp_wr_en, alu_carry, flag_c, flag_z;
  logic [5:0]    alu_control;
  logic [DW:0]   alu_sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_left = 0;

  typedef struct { int id; logic [15:0] a; logic [15:0] b; logic [5:0] op; } req_t;
  typedef struct { int id; logic [15:0] data; logic wr; logic c; logic z; int cyc; } exp_t;

  req_t rq0[$];
  req_t rq1[$];
  exp_t sb[$];

  logic m_c, m_z;
  int   m_prio;

  alu_share_arbiter dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_wr_en(rsp_wr_en), .alu_a(alu_a), .alu_b(alu_b),
    .alu_control(alu_control), .alu_result(alu_result), .alu_carry(alu_carry),
    .flag_c(flag_c), .flag_z(flag_z)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External ALU attached to the arbiter
  always_comb begin
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    alu_carry = alu_sum[DW];
    case (alu_control[3:2])
      2'b01:   alu_result = ~(alu_a & alu_b);
      2'b10:   alu_result = alu_a - alu_b;
      default: alu_result = alu_sum[DW-1:0];
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_req(input int id, input logic [15:0] a, input logic [15:0] b, input logic [5:0] op);
    req_t r;
    r.id = id; r.a = a; r.b = b; r.op = op;
    if (id == 1) rq1.push_back(r); else rq0.push_back(r);
  endtask

  // Reference model: architectural effect of one accepted request
  task automatic model_apply(input req_t r, output exp_t e);
    logic [5:0]  op;
    int          s;
    logic        carry, wr;
    logic [15:0] res;
    op = (r.id == 1) ? (r.op & 6'b001100) : r.op;
    s = int'(r.a) + int'(r.b);
    carry = (s >= 65536);
    case (op[3:2])
      2'b01:   res = ~(r.a & r.b);
      2'b10:   res = 16'((int'(r.a) - int'(r.b) + 65536) % 65536);
      default: res = 16'(s % 65536);
    endcase
    wr = (!op[5] || m_c) && (!op[4] || m_z);
    if (wr && op[0]) m_c = carry;
    if (wr && op[1]) m_z = (res == 16'h0000);
    e.id = r.id; e.data = res; e.wr = wr; e.c = m_c; e.z = m_z; e.cyc = 0;
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 3))
      0: return 16'h0000;
      1: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Present queued requests until all are accepted; expects to start just after a rising edge
  task automatic drain();
    req_t h0, h1;
    int   w, waited;
    exp_t e;
    while (rq0.size() + rq1.size() > 0) begin
      req_valid = 2'b00;
      if (rq0.size() > 0) begin
        h0 = rq0[0]; req0_a = h0.a; req0_b = h0.b; req0_op = h0.op; req_valid[0] = 1'b1;
      end
      if (rq1.size() > 0) begin
        h1 = rq1[0]; req1_a = h1.a; req1_b = h1.b; req1_op = h1.op; req_valid[1] = 1'b1;
      end
      if (req_valid == 2'b11) w = m_prio;
      else w = req_valid[1] ? 1 : 0;
      waited = 0;
      #1;
      while (req_ready == 2'b00 && waited < 40) begin
        @(posedge clk); #2;
        waited++;
      end
      if (req_ready == 2'b00) begin
        checks++; errors++;
        $display("FAIL accept_timeout: got req_ready 0 expected grant to requester %0d", w);
        rq0.delete(); rq1.delete();
      end else begin
        chk("grant", 32'(req_ready), (w == 1) ? 32'h2 : 32'h1);
        model_apply((w == 1) ? h1 : h0, e);
        e.cyc = cyc;
        sb.push_back(e);
`ifdef ALU_ARB_ROUND_ROBIN_EN
        m_prio = 1 - w;
`endif
        @(posedge clk); #1;
        if (w == 1) void'(rq1.pop_front());
        else void'(rq0.pop_front());
      end
    end
    req_valid = 2'b00;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() > 0 || rsp_valid != 2'b00) && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    if (sb.size() > 0 || rsp_valid != 2'b00) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", sb.size());
    end
  endtask

  // Monitor: drives rsp_ready, compares each response against the scoreboard head
  initial begin : monitor
    exp_t e;
    logic cap;
    cap = 1'b0;
    rsp_ready = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (rsp_valid != 2'b00 && stall_left > 0) begin
        rsp_ready = 2'b00;
        stall_left--;
      end else begin
        case ($urandom_range(0, 3))
          0: rsp_ready = 2'b00;
          1: rsp_ready = ~rsp_valid;
          default: rsp_ready = 2'b11;
        endcase
      end
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        chk("req_ready_busy", 32'(req_ready), 32'h0);
        if (!cap) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: got rsp_valid %0h expected none", rsp_valid);
            e.id = rsp_valid[1] ? 1 : 0; e.data = rsp_data; e.wr = rsp_wr_en;
          end else begin
            e = sb.pop_front();
            chk("rsp_c", 32'(flag_c), 32'(e.c));
            chk("rsp_z", 32'(flag_z), 32'(e.z));
            chk("latency", 32'(cyc - e.cyc), 32'd2);
          end
          cap = 1'b1;
        end
        chk("rsp_valid", 32'(rsp_valid), (e.id == 1) ? 32'h2 : 32'h1);
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_wr_en", 32'(rsp_wr_en), 32'(e.wr));
        if ((rsp_valid & rsp_ready) != 2'b00) cap = 1'b0;
      end
    end
  end

  initial begin : stimulus
    int n0, n1;
    reset_n = 1'b0; req_valid = 2'b00;
    req0_a = 16'h0000; req0_b = 16'h0000; req1_a = 16'h0000; req1_b = 16'h0000;
    req0_op = 6'b000000; req1_op = 6'b000000;
    m_c = 1'b0; m_z = 1'b0; m_prio = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_data", 32'(rsp_data), 32'h0);
    chk("reset_wr_en", 32'(rsp_wr_en), 32'h0);
    chk("reset_flags", 32'({flag_c, flag_z}), 32'h0);
    chk("reset_alu_ctl", 32'({alu_a, alu_b, alu_control}), 32'h0);
    @(posedge clk); #1;

    // Directed flag and conditional-write sequence
    push_req(0, 16'hFFFF, 16'h0001, 6'b000011);
    push_req(0, 16'h0003, 16'h0004, 6'b100000);
    push_req(0, 16'h0001, 16'h0001, 6'b000001);
    push_req(0, 16'h0003, 16'h0004, 6'b100000);
    push_req(1, 16'h0005, 16'h0005, 6'b110011);
    drain();
    wait_idle();

    // Simultaneous requests from both sides
    for (int i = 0; i < 4; i++) begin
      push_req(0, 16'(i), 16'h0100, 6'b000000);
      push_req(1, 16'h1000, 16'(i), 6'b001000);
    end
    drain();
    wait_idle();

    // Backpressure: first response held off for 5 cycles while another request waits
    stall_left = 5;
    push_req(0, 16'h1234, 16'h4321, 6'b000100);
    push_req(0, 16'h0F0F, 16'h00FF, 6'b000010);
    drain();
    wait_idle();

    // Reset in EXEC after flags have been set
    push_req(0, 16'hFFFF, 16'h0001, 6'b000011);
    drain();
    wait_idle();
    req0_a = 16'h0001; req0_b = 16'hFFFF; req0_op = 6'b000011; req_valid = 2'b01;
    #1 chk("rst_pre_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    reset_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_flags", 32'({flag_c, flag_z}), 32'h0);
    chk("rst_alu_ctl", 32'(alu_control), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    m_c = 1'b0; m_z = 1'b0; m_prio = 0;
    @(negedge clk);
    chk("rst_no_rsp", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1;
    push_req(1, 16'h0010, 16'h0020, 6'b000000);
    push_req(0, 16'h0000, 16'h0000, 6'b000010);
    drain();
    wait_idle();

    // Randomized batches
    for (int b = 0; b < 40; b++) begin
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      for (int i = 0; i < n0; i++) push_req(0, rnd16(), rnd16(), 6'($urandom));
      for (int i = 0; i < n1; i++) push_req(1, rnd16(), rnd16(), 6'($urandom));
      drain();
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
